// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: one writeback countdown per architectural register,
// giving a same-cycle stall plus bypass hints for variable-latency producers.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 7,
  parameter int LAT_W      = 3,
  parameter int BYPASS_EN  = 1
) (
  input  logic                  ip_clk,
  input  logic                  ip_rst,
  input  logic                  ip_valid,
  input  logic                  ip_flush,
  input  logic [REG_ADDR_W-1:0] ip_rs,
  input  logic [REG_ADDR_W-1:0] ip_rt,
  input  logic                  ip_use_rs,
  input  logic                  ip_use_rt,
  input  logic                  ip_RegWrite,
  input  logic [REG_ADDR_W-1:0] ip_dest,
  input  logic [LAT_W-1:0]      ip_latency,
  output logic                  op_stall,
  output logic                  op_fwd_rs,
  output logic                  op_fwd_rt,
  output logic [REG_ADDR_W:0]   op_pending_cnt
);

  localparam logic [LAT_W-1:0] ONE       = LAT_W'(1);
  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);
  localparam logic             BYPASS_ON = (BYPASS_EN != 0);
  // A source is only a hazard while more cycles remain than the bypass can hide.
  localparam logic [LAT_W-1:0] THRESH    = BYPASS_ON ? ONE : '0;

  logic [LAT_W-1:0]      cnt_cur [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]   busy_next;
  logic [REG_ADDR_W:0]   pending_reg;
  logic [REG_ADDR_W:0]   pending_next;

  logic [LAT_W-1:0] cnt_rs;
  logic [LAT_W-1:0] cnt_rt;
  logic [LAT_W-1:0] cnt_dest;
  logic [LAT_W-1:0] eff_lat;
  logic             in_use;
  logic             rs_live;
  logic             rt_live;
  logic             dest_live;
  logic             haz_rs;
  logic             haz_rt;
  logic             haz_waw;
  logic             stall;
  logic             issue;
  logic             set_en;

  // Register 0 has no counter, so any lookup of it reads as zero.
  always_comb begin
    cnt_rs   = '0;
    cnt_rt   = '0;
    cnt_dest = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (ip_rs == REG_ADDR_W'(r)) cnt_rs = cnt_cur[r];
      if (ip_rt == REG_ADDR_W'(r)) cnt_rt = cnt_cur[r];
      if (ip_dest == REG_ADDR_W'(r)) cnt_dest = cnt_cur[r];
    end
  end

  assign eff_lat   = (ip_latency > MAX_LAT_V) ? MAX_LAT_V : ip_latency;
  assign in_use    = ip_valid & ~ip_flush;
  assign rs_live   = in_use & ip_use_rs & (ip_rs != '0);
  assign rt_live   = in_use & ip_use_rt & (ip_rt != '0);
  assign dest_live = in_use & ip_RegWrite & (ip_dest != '0);

  assign haz_rs  = rs_live & (cnt_rs > THRESH);
  assign haz_rt  = rt_live & (cnt_rt > THRESH);
  // Holding a shorter-latency write keeps writebacks to one register in order.
  assign haz_waw = dest_live & (cnt_dest > eff_lat);
  assign stall   = haz_rs | haz_rt | haz_waw;

  assign op_stall  = stall;
  assign op_fwd_rs = rs_live & BYPASS_ON & (cnt_rs == ONE) & ~stall;
  assign op_fwd_rt = rt_live & BYPASS_ON & (cnt_rt == ONE) & ~stall;

  assign issue  = in_use & ~stall;
  assign set_en = issue & ip_RegWrite & (ip_dest != '0) & (eff_lat != '0);

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
      logic [LAT_W-1:0] cnt_reg;
      logic [LAT_W-1:0] cnt_next;
      logic             hit;

      assign hit = set_en & (ip_dest == REG_ADDR_W'(gi));

      // A fresh issue overrides this cycle's decrement of the same register.
      always_comb begin
        cnt_next = cnt_reg;
        if (hit) begin
          cnt_next = eff_lat;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - ONE;
        end
      end

      always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt_cur[gi]   = cnt_reg;
      assign busy_next[gi] = (cnt_next != '0);
    end
  endgenerate

  always_comb begin
    pending_next = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pending_next = pending_next + {{REG_ADDR_W{1'b0}}, busy_next[r]};
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign op_pending_cnt = pending_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one bypassing and one non-bypassing instance
// share the ID-stage inputs; expectations are hand-derived cycle by cycle.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int LW = 3;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          flush;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic          use_rs;
  logic          use_rt;
  logic          reg_write;
  logic [AW-1:0] dest;
  logic [LW-1:0] lat;

  logic          a_stall, a_fwd_rs, a_fwd_rt;
  logic [AW:0]   a_pend;
  logic          b_stall, b_fwd_rs, b_fwd_rt;
  logic [AW:0]   b_pend;

  int checks;
  int failures;

  hazard_scoreboard #(.BYPASS_EN(1)) u_a (
    .ip_clk(clk), .ip_rst(rst), .ip_valid(valid), .ip_flush(flush),
    .ip_rs(rs), .ip_rt(rt), .ip_use_rs(use_rs), .ip_use_rt(use_rt),
    .ip_RegWrite(reg_write), .ip_dest(dest), .ip_latency(lat),
    .op_stall(a_stall), .op_fwd_rs(a_fwd_rs), .op_fwd_rt(a_fwd_rt),
    .op_pending_cnt(a_pend)
  );

  hazard_scoreboard #(.BYPASS_EN(0)) u_b (
    .ip_clk(clk), .ip_rst(rst), .ip_valid(valid), .ip_flush(flush),
    .ip_rs(rs), .ip_rt(rt), .ip_use_rs(use_rs), .ip_use_rt(use_rt),
    .ip_RegWrite(reg_write), .ip_dest(dest), .ip_latency(lat),
    .op_stall(b_stall), .op_fwd_rs(b_fwd_rs), .op_fwd_rt(b_fwd_rt),
    .op_pending_cnt(b_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_inst(input logic v, input logic f, input int s_rs, input logic u_rs,
                          input int s_rt, input logic u_rt, input logic w, input int d,
                          input int l);
    valid     = v;
    flush     = f;
    rs        = AW'(s_rs);
    use_rs    = u_rs;
    rt        = AW'(s_rt);
    use_rt    = u_rt;
    reg_write = w;
    dest      = AW'(d);
    lat       = LW'(l);
    $display("%0t inst v=%0b f=%0b rs=%0d/%0b rt=%0d/%0b wr=%0b dest=%0d lat=%0d",
             $time, v, f, s_rs, u_rs, s_rt, u_rt, w, d, l);
  endtask

  task automatic idle();
    set_inst(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held two cycles with a live source read of r5
    rst = 1'b1;
    set_inst(1'b1, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    tick();
    tick();
    sample();
    check("rst_stall", a_stall, 0);
    check("rst_fwd_rs", a_fwd_rs, 0);
    check("rst_pend_a", a_pend, 0);
    check("rst_pend_b", b_pend, 0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // RAW on r3, latency 3; dependent reads r3 on both ports
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 3, 3);
    sample();
    check("raw_prod_stall", a_stall, 0);
    tick();
    set_inst(1'b1, 1'b0, 3, 1'b1, 3, 1'b1, 1'b0, 0, 0);
    sample();
    check("raw_c3_stall_a", a_stall, 1);
    check("raw_c3_fwd_a", a_fwd_rs, 0);
    check("raw_c3_stall_b", b_stall, 1);
    check("raw_c3_pend", a_pend, 1);
    tick();
    sample();
    check("raw_c2_stall_a", a_stall, 1);
    check("raw_c2_stall_b", b_stall, 1);
    tick();
    sample();
    check("raw_c1_stall_a", a_stall, 0);
    check("raw_c1_fwd_rs_a", a_fwd_rs, 1);
    check("raw_c1_fwd_rt_a", a_fwd_rt, 1);
    check("raw_c1_stall_b", b_stall, 1);
    check("raw_c1_fwd_b", b_fwd_rs, 0);
    tick();
    sample();
    check("raw_c0_stall_b", b_stall, 0);
    check("raw_c0_fwd_b", b_fwd_rs, 0);
    check("raw_c0_fwd_a", a_fwd_rs, 0);
    check("raw_c0_pend", a_pend, 0);
    tick();

    // Source equals own destination: no self-hazard, write still lands
    set_inst(1'b1, 1'b0, 3, 1'b1, 0, 1'b0, 1'b1, 3, 2);
    sample();
    check("self_stall_a", a_stall, 0);
    check("self_stall_b", b_stall, 0);
    tick();
    set_inst(1'b1, 1'b0, 3, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    sample();
    check("self_probe_c2", a_stall, 1);
    tick();
    sample();
    check("self_probe_c1_fwd", a_fwd_rs, 1);
    tick();
    idle();
    tick();

    // WAW on r7: lat 6 then lat 2 waits while cnt > 2
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 7, 6);
    sample();
    check("waw_first_stall", a_stall, 0);
    tick();
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 7, 2);
    for (int c = 6; c >= 3; c--) begin
      sample();
      check($sformatf("waw_c%0d_stall", c), a_stall, 1);
      tick();
    end
    sample();
    check("waw_c2_issue", a_stall, 0);
    tick();
    set_inst(1'b1, 1'b0, 7, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    sample();
    check("waw_new_cnt2", a_stall, 1);
    check("waw_pend", a_pend, 1);
    tick();
    sample();
    check("waw_new_cnt1_fwd", a_fwd_rs, 1);
    tick();
    idle();
    tick();

    // Register 0 and flush
    set_inst(1'b1, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 0, 0);
    sample();
    check("r0_stall_b", b_stall, 0);
    check("r0_fwd_a", a_fwd_rs, 0);
    tick();
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 4, 5);
    tick();
    set_inst(1'b1, 1'b1, 0, 1'b0, 4, 1'b1, 1'b1, 4, 1);
    sample();
    check("flush_stall_a", a_stall, 0);
    check("flush_stall_b", b_stall, 0);
    check("flush_fwd_rt", a_fwd_rt, 0);
    tick();
    set_inst(1'b1, 1'b0, 0, 1'b1, 4, 1'b1, 1'b0, 0, 0);
    sample();
    check("flush_no_update", a_stall, 1);
    check("flush_pend", a_pend, 1);
    tick();
    tick();
    tick();
    sample();
    check("flush_c1_fwd_rt", a_fwd_rt, 1);
    check("flush_c1_fwd_rs0", a_fwd_rs, 0);
    tick();
    idle();
    tick();

    // Pending count and full-latency countdown on r9
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 9, 7);
    sample();
    check("pend_before", a_pend, 0);
    tick();
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 10, 1);
    sample();
    check("pend_one", a_pend, 1);
    tick();
    set_inst(1'b1, 1'b0, 9, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    sample();
    check("pend_two", a_pend, 2);
    check("r9_c6_stall_b", b_stall, 1);
    tick();
    sample();
    check("pend_back_one", a_pend, 1);
    tick();
    tick();
    tick();
    tick();
    sample();
    check("r9_c1_stall_b", b_stall, 1);
    check("r9_c1_pend", b_pend, 1);
    tick();
    sample();
    check("r9_c0_stall_b", b_stall, 0);
    check("r9_c0_pend", b_pend, 0);
    tick();

    // Reset while two counters are live, with a competing issue
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 9, 7);
    tick();
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 10, 5);
    tick();
    idle();
    sample();
    check("pre_rst_pend", a_pend, 2);
    tick();
    rst = 1'b1;
    set_inst(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 11, 3);
    tick();
    rst = 1'b0;
    set_inst(1'b1, 1'b0, 9, 1'b1, 10, 1'b1, 1'b0, 0, 0);
    sample();
    check("mid_rst_pend_a", a_pend, 0);
    check("mid_rst_pend_b", b_pend, 0);
    check("mid_rst_stall_b", b_stall, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
